regf_bus_initiator: RTL and testbench

- Bus initiator for the regf `mem_*` responder port. It drives `mem_ena/addr/wena/wdata` and samples `mem_rdata/mem_err`.
- It accepts single-word commands (READ, WRITE, masked READ-MODIFY-WRITE) on a valid/ready command channel and returns one response per command on a valid/ready response channel.
- It sits between a host-side controller (debug bridge, sequencer) and one or more generated register files.

---
 rtl/regf_bus_initiator_pkg.sv | 30 +++
 rtl/regf_bus_initiator.sv | 141 ++++++++++++++
 tb/tb_regf_bus_initiator.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regf_bus_initiator_pkg.sv
// Shared types and helpers for the regf bus initiator.
package regf_bus_initiator_pkg;

    // Widest data word the merge helper handles; callers size-cast in and out.
    localparam int unsigned MERGE_W = 64;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_RMW   = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RSP
    } state_e;

    // Masked merge: a 1 in mask takes the bit from wdata, a 0 keeps the read bit.
    function automatic logic [MERGE_W-1:0] rmw_merge(
        input logic [MERGE_W-1:0] rdata,
        input logic [MERGE_W-1:0] wdata,
        input logic [MERGE_W-1:0] mask
    );
        return (rdata & ~mask) | (wdata & mask);
    endfunction

endpackage

// File: rtl/regf_bus_initiator.sv
// Single-outstanding bus initiator for the regf mem_* responder port.
// Accepts READ / WRITE / masked RMW commands and returns one response each.
module regf_bus_initiator
    import regf_bus_initiator_pkg::*;
#(
    parameter int unsigned addr_width_p = 13,
    parameter int unsigned data_width_p = 32
) (
    input  logic                    main_clk_i,
    input  logic                    main_rst_i,

    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [1:0]              cmd_op_i,
    input  logic [addr_width_p-1:0] cmd_addr_i,
    input  logic [data_width_p-1:0] cmd_wdata_i,
    input  logic [data_width_p-1:0] cmd_mask_i,

    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [data_width_p-1:0] rsp_rdata_o,
    output logic                    rsp_err_o,

    output logic                    mem_ena_o,
    output logic [addr_width_p-1:0] mem_addr_o,
    output logic                    mem_wena_o,
    output logic [data_width_p-1:0] mem_wdata_o,
    input  logic [data_width_p-1:0] mem_rdata_i,
    input  logic                    mem_err_i
);

    // Low address bits that must be zero for a word-aligned access.
    localparam logic [addr_width_p-1:0] ALIGN_MASK = addr_width_p'(data_width_p / 8 - 1);

    state_e                  r_state;
    op_e                     r_op;
    logic [data_width_p-1:0] r_wdata;
    logic [data_width_p-1:0] r_mask;

    op_e                     w_op;
    logic                    w_misaligned;
    logic                    w_reject;
    logic                    w_accept;
    logic [data_width_p-1:0] w_merged;

    // Decode of the incoming command and the RMW write value.
    always_comb begin
        w_op         = op_e'(cmd_op_i);
        w_misaligned = (cmd_addr_i & ALIGN_MASK) != '0;
        w_reject     = w_misaligned || (w_op == OP_RSVD);
        w_accept     = cmd_valid_i && cmd_ready_o;
        w_merged     = data_width_p'(rmw_merge(MERGE_W'(mem_rdata_i),
                                               MERGE_W'(r_wdata),
                                               MERGE_W'(r_mask)));
    end

    // Command FSM; every output is a register updated here.
    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_READ;
            r_wdata     <= '0;
            r_mask      <= '0;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            mem_ena_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wena_o  <= 1'b0;
            mem_wdata_o <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        cmd_ready_o <= 1'b0;
                        r_op        <= w_op;
                        r_wdata     <= cmd_wdata_i;
                        r_mask      <= cmd_mask_i;
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b0;
                        if (w_reject) begin
                            rsp_err_o   <= 1'b1;
                            rsp_valid_o <= 1'b1;
                            r_state     <= ST_RSP;
                        end else begin
                            mem_ena_o  <= 1'b1;
                            mem_addr_o <= cmd_addr_i;
                            if (w_op == OP_WRITE) begin
                                mem_wena_o  <= 1'b1;
                                mem_wdata_o <= cmd_wdata_i;
                                r_state     <= ST_WR;
                            end else begin
                                mem_wena_o <= 1'b0;
                                r_state    <= ST_RD;
                            end
                        end
                    end else begin
                        cmd_ready_o <= 1'b1;
                    end
                end

                ST_RD: begin
                    rsp_rdata_o <= mem_rdata_i;
                    rsp_err_o   <= mem_err_i;
                    // mem_ena_o stays high into the RMW write: two back-to-back
                    // single-cycle accesses rather than one long one.
                    if ((r_op == OP_RMW) && !mem_err_i) begin
                        mem_wena_o  <= 1'b1;
                        mem_wdata_o <= w_merged;
                        r_state     <= ST_WR;
                    end else begin
                        mem_ena_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end

                ST_WR: begin
                    mem_ena_o   <= 1'b0;
                    rsp_err_o   <= rsp_err_o | mem_err_i;
                    rsp_valid_o <= 1'b1;
                    r_state     <= ST_RSP;
                end

                ST_RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regf_bus_initiator.sv
// Self-checking bench for regf_bus_initiator: directed table, random commands
// against a memory-level reference model, and a reset-mid-RMW sequence.
module tb_regf_bus_initiator;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [1:0]    cmd_op_i = '0;
    logic [AW-1:0] cmd_addr_i = '0;
    logic [DW-1:0] cmd_wdata_i = '0;
    logic [DW-1:0] cmd_mask_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          mem_ena_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_wena_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_err_i;

    always #5 clk = ~clk;

    regf_bus_initiator #(
        .addr_width_p(AW),
        .data_width_p(DW)
    ) dut (
        .main_clk_i (clk),
        .main_rst_i (rst),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_op_i   (cmd_op_i),
        .cmd_addr_i (cmd_addr_i),
        .cmd_wdata_i(cmd_wdata_i),
        .cmd_mask_i (cmd_mask_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o  (rsp_err_o),
        .mem_ena_o  (mem_ena_o),
        .mem_addr_o (mem_addr_o),
        .mem_wena_o (mem_wena_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_err_i  (mem_err_i)
    );

    // ---------------- responder: word memory with a decode-error window
    function automatic logic is_err(input logic [AW-1:0] a);
        return ((a >= 13'h0010) && (a < 13'h0020)) || (a >= 13'h1000);
    endfunction

    logic [DW-1:0] rmem [0:2047];
    logic          preload = 1'b1;

    assign mem_rdata_i = rmem[mem_addr_o[12:2]];
    assign mem_err_i   = is_err(mem_addr_o);

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 2048; i++) rmem[i] <= '0;
            rmem[1] <= 32'h0000_00A5;
            rmem[2] <= 32'hF0F0_F0F0;
        end else if (mem_ena_o && mem_wena_o && !is_err(mem_addr_o)) begin
            rmem[mem_addr_o[12:2]] <= mem_wdata_o;
        end
    end

    // ---------------- bus monitor (counts only, never reset)
    int            n_rd = 0;
    int            n_wr = 0;
    logic [DW-1:0] last_wdata = '0;
    logic [AW-1:0] last_addr = '0;

    always @(negedge clk) begin
        if (mem_ena_o) begin
            if (mem_wena_o) begin
                n_wr++;
                last_wdata = mem_wdata_o;
            end else begin
                n_rd++;
            end
            last_addr = mem_addr_o;
        end
    end

    // ---------------- checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one command from a negedge, check latency, response, backpressure,
    // handoff and the bus activity it caused. Returns at a negedge.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [DW-1:0] mk, input int hold,
                           input logic [DW-1:0] exp_rdata, input logic exp_err, input int exp_lat,
                           input int exp_rd, input int exp_wr, input logic [DW-1:0] exp_wdata);
        int w;
        int lat;
        int rd0;
        int wr0;
        cmd_op_i    = op;
        cmd_addr_i  = addr;
        cmd_wdata_i = wd;
        cmd_mask_i  = mk;
        cmd_valid_i = 1'b1;
        w = 0;
        while (!cmd_ready_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready_o) begin
            chk({tag, " accept_timeout"}, 32'(cmd_ready_o), 32'd1);
            cmd_valid_i = 1'b0;
            return;
        end
        rd0 = n_rd;
        wr0 = n_wr;
        @(posedge clk);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        cmd_op_i    = 2'($urandom);
        cmd_addr_i  = AW'($urandom);
        cmd_wdata_i = $urandom;
        cmd_mask_i  = $urandom;
        lat = 1;
        while (!rsp_valid_o && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        if (!rsp_valid_o) return;
        chk({tag, " rdata"}, rsp_rdata_o, exp_rdata);
        chk({tag, " err"}, 32'(rsp_err_o), 32'(exp_err));
        chk({tag, " ready_low"}, 32'(cmd_ready_o), 32'd0);
        repeat (hold) begin
            @(negedge clk);
            chk({tag, " stall_valid"}, 32'(rsp_valid_o), 32'd1);
            chk({tag, " stall_rdata"}, rsp_rdata_o, exp_rdata);
            chk({tag, " stall_err"}, 32'(rsp_err_o), 32'(exp_err));
            chk({tag, " stall_ready"}, 32'(cmd_ready_o), 32'd0);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready_i = 1'b0;
        chk({tag, " valid_drop"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, " ready_back"}, 32'(cmd_ready_o), 32'd1);
        chk({tag, " bus_reads"}, 32'(n_rd - rd0), 32'(exp_rd));
        chk({tag, " bus_writes"}, 32'(n_wr - wr0), 32'(exp_wr));
        if (exp_rd + exp_wr > 0) chk({tag, " bus_addr"}, 32'(last_addr), 32'(addr));
        if (exp_wr > 0) chk({tag, " bus_wdata"}, last_wdata, exp_wdata);
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] mk;
        int            hold;
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
        int            nrd;
        int            nwr;
        logic [DW-1:0] wdat;
    } vec_t;

    vec_t          tbl [11];
    logic [DW-1:0] mmem [0:2047];

    initial begin
        #400000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] mk;
        logic [DW-1:0] e_rdata;
        logic [DW-1:0] e_wdat;
        logic          e_err;
        int            e_lat;
        int            e_rd;
        int            e_wr;
        int            r;

        //               op     addr      wdata         mask          hold rdata         err   lat rd wr wdata
        tbl[0]  = '{2'd1, 13'h0000, 32'h0000_0001, 32'h0000_0000, 0, 32'h0000_0000, 1'b0, 2, 0, 1, 32'h0000_0001};
        tbl[1]  = '{2'd0, 13'h0004, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_00A5, 1'b0, 2, 1, 0, 32'h0000_0000};
        tbl[2]  = '{2'd2, 13'h0008, 32'h1234_5678, 32'h0000_FFFF, 0, 32'hF0F0_F0F0, 1'b0, 3, 1, 1, 32'hF0F0_5678};
        tbl[3]  = '{2'd0, 13'h0008, 32'h0000_0000, 32'h0000_0000, 1, 32'hF0F0_5678, 1'b0, 2, 1, 0, 32'h0000_0000};
        tbl[4]  = '{2'd0, 13'h0010, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_0000, 1'b1, 2, 1, 0, 32'h0000_0000};
        tbl[5]  = '{2'd2, 13'h0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0000_0000, 1'b1, 2, 1, 0, 32'h0000_0000};
        tbl[6]  = '{2'd0, 13'h0002, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_0000, 1'b1, 1, 0, 0, 32'h0000_0000};
        tbl[7]  = '{2'd3, 13'h0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 32'h0000_0000, 1'b1, 1, 0, 0, 32'h0000_0000};
        tbl[8]  = '{2'd0, 13'h0000, 32'h0000_0000, 32'h0000_0000, 3, 32'h0000_0001, 1'b0, 2, 1, 0, 32'h0000_0000};
        tbl[9]  = '{2'd1, 13'h0011, 32'hAAAA_AAAA, 32'h0000_0000, 0, 32'h0000_0000, 1'b1, 1, 0, 0, 32'h0000_0000};
        tbl[10] = '{2'd2, 13'h0003, 32'h5555_5555, 32'hFFFF_0000, 2, 32'h0000_0000, 1'b1, 1, 0, 0, 32'h0000_0000};

        for (int i = 0; i < 2048; i++) mmem[i] = '0;
        mmem[1] = 32'h0000_00A5;
        mmem[2] = 32'hF0F0_F0F0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst cmd_ready", 32'(cmd_ready_o), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst rsp_rdata", rsp_rdata_o, 32'd0);
        chk("rst rsp_err", 32'(rsp_err_o), 32'd0);
        chk("rst mem_ena", 32'(mem_ena_o), 32'd0);
        chk("rst mem_addr", 32'(mem_addr_o), 32'd0);
        chk("rst mem_wena", 32'(mem_wena_o), 32'd0);
        chk("rst mem_wdata", mem_wdata_o, 32'd0);
        preload = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst cmd_ready", 32'(cmd_ready_o), 32'd1);

        // directed table
        for (int i = 0; i < 11; i++) begin
            run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].mk,
                    tbl[i].hold, tbl[i].rdata, tbl[i].err, tbl[i].lat, tbl[i].nrd,
                    tbl[i].nwr, tbl[i].wdat);
            if (tbl[i].nwr > 0 && !tbl[i].err) mmem[tbl[i].addr[12:2]] = tbl[i].wdat;
        end

        // random commands against the memory-level model
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            op = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            addr = AW'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) addr = addr | AW'($urandom_range(1, 3));
            wd = $urandom;
            mk = $urandom;
            e_wdat = '0;
            if (addr[1:0] != 2'b00 || op == 2'd3) begin
                e_rdata = '0; e_err = 1'b1; e_lat = 1; e_rd = 0; e_wr = 0;
            end else if (op == 2'd0) begin
                e_rdata = mmem[addr[12:2]]; e_err = is_err(addr); e_lat = 2; e_rd = 1; e_wr = 0;
            end else if (op == 2'd1) begin
                e_rdata = '0; e_err = is_err(addr); e_lat = 2; e_rd = 0; e_wr = 1; e_wdat = wd;
                if (!e_err) mmem[addr[12:2]] = wd;
            end else begin
                e_rdata = mmem[addr[12:2]];
                if (is_err(addr)) begin
                    e_err = 1'b1; e_lat = 2; e_rd = 1; e_wr = 0;
                end else begin
                    e_err = 1'b0; e_lat = 3; e_rd = 1; e_wr = 1;
                    e_wdat = (e_rdata & ~mk) | (wd & mk);
                    mmem[addr[12:2]] = e_wdat;
                end
            end
            run_cmd($sformatf("rnd%0d", n), op, addr, wd, mk, $urandom_range(0, 2),
                    e_rdata, e_err, e_lat, e_rd, e_wr, e_wdat);
        end

        // reset during the write cycle of an RMW
        wd = 32'hCAFE_0000;
        mk = 32'hFFFF_0000;
        cmd_op_i    = 2'd2;
        cmd_addr_i  = 13'h0020;
        cmd_wdata_i = wd;
        cmd_mask_i  = mk;
        cmd_valid_i = 1'b1;
        chk("rstseq ready", 32'(cmd_ready_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        chk("rstseq rd_ena", 32'(mem_ena_o), 32'd1);
        chk("rstseq rd_wena", 32'(mem_wena_o), 32'd0);
        @(negedge clk);
        chk("rstseq wr_ena", 32'(mem_ena_o), 32'd1);
        chk("rstseq wr_wena", 32'(mem_wena_o), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstseq ena_drop", 32'(mem_ena_o), 32'd0);
        chk("rstseq no_rsp", 32'(rsp_valid_o), 32'd0);
        chk("rstseq ready_low", 32'(cmd_ready_o), 32'd0);
        rst = 1'b0;
        // the write cycle completed on the bus at the reset edge
        mmem[8] = (mmem[8] & ~mk) | (wd & mk);
        @(posedge clk);
        @(negedge clk);
        chk("rstseq ready_back", 32'(cmd_ready_o), 32'd1);
        repeat (3) @(negedge clk);
        chk("rstseq still_no_rsp", 32'(rsp_valid_o), 32'd0);
        run_cmd("post_rst_read", 2'd0, 13'h0020, 32'd0, 32'd0, 0, mmem[8], 1'b0, 2, 1, 0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
